// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared register offsets and FSM encoding for irq_ctrl
package irq_pkg;

  typedef logic [1:0] state_t;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_ENABLE  = 2'd1;
  localparam logic [1:0] REG_CAUSE   = 2'd2;
  localparam logic [1:0] REG_SWTRIG  = 2'd3;

  localparam state_t IDLE    = 2'd0;
  localparam state_t REQ     = 2'd1;
  localparam state_t SERVICE = 2'd2;

endpackage

// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - register bus and CPU interrupt handshake bundle
interface irq_ctrl_if #(
  parameter int SRC_W = 3
);

  logic             reg_we;
  logic [1:0]       reg_addr;
  logic [31:0]      reg_wdata;
  logic [31:0]      reg_rdata;
  logic             int_req;
  logic             int_ack;
  logic             int_eoi;
  logic [SRC_W-1:0] cause_id;
  logic             busy;

  // CPU / bus decode side
  modport master (
    output reg_we, reg_addr, reg_wdata, int_ack, int_eoi,
    input  reg_rdata, int_req, cause_id, busy
  );

  // interrupt controller side
  modport slave (
    input  reg_we, reg_addr, reg_wdata, int_ack, int_eoi,
    output reg_rdata, int_req, cause_id, busy
  );

endinterface

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - two-flop synchroniser plus rising-edge detector for one source
module irq_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // metastability filter (s1, s2) followed by the edge-history flop s3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= src;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // one-cycle pulse on a synchronised 0->1 transition
  assign rise = s2 & ~s3;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - edge-triggered, fixed-priority interrupt controller for the SCPU
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int SRC_W   = 3
) (
  input  logic               clk,
  input  logic               RSTN,
  input  logic [NUM_SRC-1:0] irq_src,
  irq_ctrl_if.slave          bus
);

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] win_oh;
  logic [NUM_SRC-1:0] set_mask;
  logic [NUM_SRC-1:0] clr_mask;
  logic [SRC_W-1:0]   win_id;
  logic [SRC_W-1:0]   cause_q;
  state_t             state;
  state_t             state_nxt;
  logic               take_ack;
  logic               wr_pending;
  logic               wr_enable;
  logic               wr_swtrig;
  logic               unused_wdata;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      irq_sync_edge u_sync (
        .clk   (clk),
        .rst_n (RSTN),
        .src   (irq_src[gi]),
        .rise  (rise[gi])
      );
    end
  endgenerate

  assign wr_pending   = bus.reg_we && (bus.reg_addr == REG_PENDING);
  assign wr_enable    = bus.reg_we && (bus.reg_addr == REG_ENABLE);
  assign wr_swtrig    = bus.reg_we && (bus.reg_addr == REG_SWTRIG);
  assign unused_wdata = ^bus.reg_wdata[31:NUM_SRC];

  assign active = pending & enable;

  // fixed priority: scanning downwards leaves the lowest active index as winner
  always_comb begin
    win_oh = '0;
    win_id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        win_oh    = '0;
        win_oh[i] = 1'b1;
        win_id    = SRC_W'(i);
      end
    end
  end

  // an acknowledge only counts while requesting and something is still active
  assign take_ack = (state == REQ) && (|active) && bus.int_ack;

  // set beats clear, so an edge landing with a W1C or an ack keeps the bit
  assign set_mask = rise | (wr_swtrig ? bus.reg_wdata[NUM_SRC-1:0] : '0);
  assign clr_mask = (wr_pending ? bus.reg_wdata[NUM_SRC-1:0] : '0) |
                    (take_ack ? win_oh : '0);

  // request / service sequencing
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|active) state_nxt = REQ;
      REQ: begin
        if (!(|active))       state_nxt = IDLE;
        else if (bus.int_ack) state_nxt = SERVICE;
      end
      SERVICE: if (bus.int_eoi) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // state, pending, enable and cause registers
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      state   <= IDLE;
      pending <= '0;
      enable  <= '0;
      cause_q <= '0;
    end else begin
      state   <= state_nxt;
      pending <= (pending & ~clr_mask) | set_mask;
      if (wr_enable) enable  <= bus.reg_wdata[NUM_SRC-1:0];
      if (take_ack)  cause_q <= win_id;
    end
  end

  assign bus.int_req  = (state == REQ);
  assign bus.busy     = (state == SERVICE);
  assign bus.cause_id = cause_q;

  // register read mux, combinational from the address
  always_comb begin
    bus.reg_rdata = '0;
    case (bus.reg_addr)
      REG_PENDING: bus.reg_rdata = {{(32-NUM_SRC){1'b0}}, pending};
      REG_ENABLE:  bus.reg_rdata = {{(32-NUM_SRC){1'b0}}, enable};
      REG_CAUSE:   bus.reg_rdata = {{(31-SRC_W){1'b0}}, (state == SERVICE), cause_q};
      default:     bus.reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb/tb_irq_ctrl.sv - self-checking bench for irq_ctrl
module tb_irq_ctrl;

  localparam int N = 4;
  localparam int W = 3;
  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_SVC  = 2;

  logic         clk = 1'b0;
  logic         RSTN;
  logic [N-1:0] irq_src;
  int           n_vec = 0;
  int           n_err = 0;

  irq_ctrl_if #(.SRC_W(W)) bus ();

  irq_ctrl #(.NUM_SRC(N), .SRC_W(W)) dut (
    .clk     (clk),
    .RSTN    (RSTN),
    .irq_src (irq_src),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // reference model: behaviour derived from the interrupt rules
  logic [N-1:0] h0, h1, h2;
  logic [N-1:0] m_pend, m_en, m_act, m_edge;
  logic [W-1:0] m_cause;
  int           m_state;
  int           m_win;
  logic         m_take;

  function automatic int model_win(input logic [N-1:0] a);
    for (int i = 0; i < N; i++) if (a[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] model_rdata(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_pend);
      2'd1:    return 32'(m_en);
      2'd2:    return {28'd0, (m_state == M_SVC), m_cause};
      default: return 32'd0;
    endcase
  endfunction

  assign m_act  = m_pend & m_en;
  assign m_edge = h1 & ~h2;
  always_comb m_win = model_win(m_act);
  assign m_take = (m_state == M_REQ) && (m_win >= 0) && bus.int_ack;

  always @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      h0 <= '0; h1 <= '0; h2 <= '0;
      m_pend <= '0; m_en <= '0; m_cause <= '0; m_state <= M_IDLE;
    end else begin
      h0 <= irq_src; h1 <= h0; h2 <= h1;
      if (bus.reg_we && bus.reg_addr == 2'd1) m_en <= bus.reg_wdata[N-1:0];
      m_pend <= (m_pend
                 & ~((bus.reg_we && bus.reg_addr == 2'd0) ? bus.reg_wdata[N-1:0] : '0)
                 & ~(m_take ? (N'(1) << m_win) : '0))
                | m_edge
                | ((bus.reg_we && bus.reg_addr == 2'd3) ? bus.reg_wdata[N-1:0] : '0);
      case (m_state)
        M_IDLE: if (m_win >= 0) m_state <= M_REQ;
        M_REQ: begin
          if (m_win < 0) m_state <= M_IDLE;
          else if (bus.int_ack) begin
            m_state <= M_SVC;
            m_cause <= W'(m_win);
          end
        end
        default: if (bus.int_eoi) m_state <= M_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
    bus.reg_we = 1'b1; bus.reg_addr = a; bus.reg_wdata = d;
    tick();
    bus.reg_we = 1'b0; bus.reg_wdata = '0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.reg_addr = a;
    #1;
    d = bus.reg_rdata;
  endtask

  task automatic pulse_ack();
    bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.int_eoi = 1'b1; tick(); bus.int_eoi = 1'b0;
  endtask

  task automatic pulse_src(input int i);
    irq_src[i] = 1'b1; tick(); irq_src[i] = 1'b0;
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    while (!bus.int_req && n < 20) begin
      tick();
      n++;
    end
    ok = bus.int_req;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    RSTN = 1'b1; irq_src = '0;
    bus.reg_we = 0; bus.reg_addr = 0; bus.reg_wdata = 0; bus.int_ack = 0; bus.int_eoi = 0;
    #2 RSTN = 1'b0;
    tick(); tick();
    n_vec++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL reset_int_req: got %0b want 0", bus.int_req); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    n_vec++; if (bus.cause_id !== 3'd0) begin n_err++; $display("FAIL reset_cause: got %0d want 0", bus.cause_id); end
    rd(2'd0, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_pending: got %0h want 0", d); end
    rd(2'd1, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL reset_enable: got %0h want 0", d); end
    @(posedge clk); #1 RSTN = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [31:0] d;
    reg_write(2'd1, 32'h5);
    pulse_src(2);
    tick();
    tick();
    rd(2'd0, d);
    n_vec++; if (d !== 32'd4) begin n_err++; $display("FAIL basic_pending: got %0h want 4", d); end
    n_vec++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL basic_req_early: got %0b want 0", bus.int_req); end
    tick();
    n_vec++; if (bus.int_req !== 1'b1) begin n_err++; $display("FAIL basic_req_4cyc: got %0b want 1", bus.int_req); end
    pulse_ack();
    n_vec++; if (bus.cause_id !== 3'd2) begin n_err++; $display("FAIL basic_cause: got %0d want 2", bus.cause_id); end
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %0b want 1", bus.busy); end
    n_vec++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL basic_req_drop: got %0b want 0", bus.int_req); end
    rd(2'd0, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL basic_pend_clr: got %0h want 0", d); end
    rd(2'd2, d);
    n_vec++; if (d !== 32'hA) begin n_err++; $display("FAIL basic_cause_reg: got %0h want a", d); end
    pulse_eoi();
    n_vec++; if (bus.busy !== 1'b0 || bus.int_req !== 1'b0) begin n_err++; $display("FAIL basic_eoi: busy=%0b req=%0b want 0 0", bus.busy, bus.int_req); end
    tick();
  endtask

  task automatic test_overtake();
    logic [31:0] d;
    bit ok;
    pulse_src(2);
    wait_req(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL overtake_req: got 0 want 1"); end
    pulse_src(0);
    tick(); tick();
    pulse_ack();
    n_vec++; if (bus.cause_id !== 3'd0) begin n_err++; $display("FAIL overtake_cause: got %0d want 0", bus.cause_id); end
    rd(2'd0, d);
    n_vec++; if (d !== 32'd4) begin n_err++; $display("FAIL overtake_pend: got %0h want 4", d); end
    pulse_eoi();
    n_vec++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL overtake_idle: got %0b want 0", bus.int_req); end
    tick();
    n_vec++; if (bus.int_req !== 1'b1) begin n_err++; $display("FAIL overtake_rereq: got %0b want 1", bus.int_req); end
    pulse_ack();
    n_vec++; if (bus.cause_id !== 3'd2) begin n_err++; $display("FAIL overtake_cause2: got %0d want 2", bus.cause_id); end
    pulse_eoi();
    tick();
  endtask

  task automatic test_mask();
    logic [31:0] d;
    reg_write(2'd1, 32'h0);
    pulse_src(1);
    tick(); tick(); tick();
    n_vec++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL mask_req: got %0b want 0", bus.int_req); end
    rd(2'd0, d);
    n_vec++; if (d !== 32'd2) begin n_err++; $display("FAIL mask_pend: got %0h want 2", d); end
    reg_write(2'd1, 32'h2);
    n_vec++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL mask_req1: got %0b want 0", bus.int_req); end
    tick();
    n_vec++; if (bus.int_req !== 1'b1) begin n_err++; $display("FAIL mask_req2: got %0b want 1", bus.int_req); end
    pulse_ack();
    n_vec++; if (bus.cause_id !== 3'd1) begin n_err++; $display("FAIL mask_cause: got %0d want 1", bus.cause_id); end
    pulse_eoi();
    tick();
  endtask

  task automatic test_w1c_swtrig();
    logic [31:0] d;
    bit ok;
    reg_write(2'd1, 32'h0);
    pulse_src(0);
    tick();
    reg_write(2'd0, 32'h1);
    rd(2'd0, d);
    n_vec++; if (d !== 32'd1) begin n_err++; $display("FAIL w1c_set_wins: got %0h want 1", d); end
    reg_write(2'd0, 32'h1);
    rd(2'd0, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL w1c_clear: got %0h want 0", d); end
    reg_write(2'd1, 32'h8);
    reg_write(2'd3, 32'h8);
    rd(2'd3, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL swtrig_read: got %0h want 0", d); end
    wait_req(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL swtrig_req: got 0 want 1"); end
    pulse_ack();
    n_vec++; if (bus.cause_id !== 3'd3) begin n_err++; $display("FAIL swtrig_cause: got %0d want 3", bus.cause_id); end
    pulse_eoi();
    tick();
  endtask

  task automatic test_req_cancel();
    logic [31:0] d;
    bit ok;
    reg_write(2'd3, 32'h8);
    wait_req(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL cancel_req: got 0 want 1"); end
    reg_write(2'd0, 32'h8);
    rd(2'd0, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL cancel_pend: got %0h want 0", d); end
    tick();
    n_vec++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL cancel_drop: got %0b want 0", bus.int_req); end
    pulse_ack();
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL cancel_ack_busy: got %0b want 0", bus.busy); end
    n_vec++; if (bus.cause_id !== 3'd3) begin n_err++; $display("FAIL cancel_cause: got %0d want 3", bus.cause_id); end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] exp_rd;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 3) == 0) irq_src = N'($urandom);
      bus.reg_we    = ($urandom_range(0, 2) == 0);
      bus.reg_addr  = 2'($urandom);
      bus.reg_wdata = $urandom;
      bus.int_ack   = ($urandom_range(0, 2) == 0);
      bus.int_eoi   = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      exp_rd = model_rdata(bus.reg_addr);
      n_vec++; if (bus.int_req !== (m_state == M_REQ)) begin n_err++; $display("FAIL rnd_req c%0d: got %0b want %0b", c, bus.int_req, (m_state == M_REQ)); end
      n_vec++; if (bus.busy !== (m_state == M_SVC)) begin n_err++; $display("FAIL rnd_busy c%0d: got %0b want %0b", c, bus.busy, (m_state == M_SVC)); end
      n_vec++; if (bus.cause_id !== m_cause) begin n_err++; $display("FAIL rnd_cause c%0d: got %0d want %0d", c, bus.cause_id, m_cause); end
      n_vec++; if (bus.reg_rdata !== exp_rd) begin n_err++; $display("FAIL rnd_rdata c%0d a%0d: got %0h want %0h", c, bus.reg_addr, bus.reg_rdata, exp_rd); end
    end
    @(posedge clk); #1;
    irq_src = '0; bus.reg_we = 0; bus.int_ack = 0; bus.int_eoi = 0;
    tick(); tick(); tick();
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    bit ok;
    RSTN = 1'b0; tick(); RSTN = 1'b1; tick();
    reg_write(2'd1, 32'h8);
    reg_write(2'd3, 32'h8);
    wait_req(ok);
    pulse_ack();
    n_vec++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL arst_pre_busy: got %0b want 1", bus.busy); end
    #2 RSTN = 1'b0;
    #1;
    n_vec++; if (bus.int_req !== 1'b0 || bus.busy !== 1'b0) begin n_err++; $display("FAIL arst_outs: req=%0b busy=%0b want 0 0", bus.int_req, bus.busy); end
    n_vec++; if (bus.cause_id !== 3'd0) begin n_err++; $display("FAIL arst_cause: got %0d want 0", bus.cause_id); end
    rd(2'd0, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL arst_pend: got %0h want 0", d); end
    rd(2'd1, d);
    n_vec++; if (d !== 32'd0) begin n_err++; $display("FAIL arst_en: got %0h want 0", d); end
    @(posedge clk); #1 RSTN = 1'b1;
    reg_write(2'd1, 32'h8);
    tick(); tick(); tick();
    n_vec++; if (bus.int_req !== 1'b0) begin n_err++; $display("FAIL arst_no_req: got %0b want 0", bus.int_req); end
    pulse_src(3);
    wait_req(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL arst_new_edge: got 0 want 1"); end
    pulse_ack();
    pulse_eoi();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overtake();
    test_mask();
    test_w1c_swtrig();
    test_req_cancel();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
